// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, drives the i-mem read handshake
// and buffers words in a small queue. Define FETCH_PERF_EN for perf counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h00000060,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] i_addr,
  output logic        i_read,
  input  logic [31:0] i_rdata,
  input  logic        i_resp,
  input  logic        ex_load_pc,
  input  logic [31:0] ex_target,
  input  logic        stall_id,
  output logic        inst_valid,
  output logic [31:0] instruction,
  output logic [31:0] pc_out
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_discarded
`endif
);

  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);
  localparam logic [31:0]   NOP     = 32'h00000013;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t          state_r, state_next_s;
  logic [31:0]     i_addr_r, i_addr_next_s;
  logic            i_read_r, i_read_next_s;
  logic [31:0]     redir_pc_r, redir_pc_next_s;
  logic [31:0]     q_pc_r   [QUEUE_DEPTH];
  logic [31:0]     q_inst_r [QUEUE_DEPTH];
  logic [PW-1:0]   wr_ptr_r, rd_ptr_r, rd_ptr_next_s;
  logic [CW-1:0]   count_r, count_next_s, remain_s;
  logic            inst_valid_r, inst_valid_next_s;
  logic [31:0]     instruction_r, instruction_next_s;
  logic [31:0]     pc_out_r, pc_out_next_s;
  logic            resp_s, pop_s, enq_s, held_s, drop_s;
  logic [31:0]     target_s;

  // Next-state, handshake and queue-head computation.
  always_comb begin
    resp_s   = i_resp & i_read_r;
    pop_s    = inst_valid_r & ~stall_id & ~ex_load_pc;
    enq_s    = resp_s & (state_r != ST_DRAIN) & ~ex_load_pc;
    drop_s   = resp_s & ((state_r == ST_DRAIN) | ex_load_pc);
    held_s   = i_read_r & ~resp_s;
    target_s = {ex_target[31:2], 2'b00};

    if (ex_load_pc) begin
      count_next_s = {CW{1'b0}};
    end else begin
      count_next_s = count_r + {{(CW-1){1'b0}}, enq_s} - {{(CW-1){1'b0}}, pop_s};
    end
    remain_s = count_r - {{(CW-1){1'b0}}, pop_s};

    if (ex_load_pc) begin
      redir_pc_next_s = target_s;
    end else begin
      redir_pc_next_s = redir_pc_r;
    end

    // A request in flight is never withdrawn: address stays put until its response.
    if (held_s) begin
      i_addr_next_s = i_addr_r;
    end else if (ex_load_pc) begin
      i_addr_next_s = target_s;
    end else if (state_r == ST_DRAIN) begin
      i_addr_next_s = redir_pc_r;
    end else if (resp_s) begin
      i_addr_next_s = i_addr_r + 32'd4;
    end else begin
      i_addr_next_s = i_addr_r;
    end

    if (held_s) begin
      i_read_next_s = 1'b1;
    end else begin
      i_read_next_s = (count_next_s < DEPTH_C);
    end

    case (state_r)
      ST_FETCH, ST_HOLD: begin
        if (ex_load_pc && held_s) begin
          state_next_s = ST_DRAIN;
        end else if (i_read_next_s) begin
          state_next_s = ST_FETCH;
        end else begin
          state_next_s = ST_HOLD;
        end
      end
      ST_DRAIN: begin
        if (held_s) begin
          state_next_s = ST_DRAIN;
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      default: state_next_s = ST_FETCH;
    endcase

    if (pop_s) begin
      rd_ptr_next_s = rd_ptr_r + 1'b1;
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end

    // Head after the edge: empty, the word arriving now, or an already-stored entry.
    if (count_next_s == {CW{1'b0}}) begin
      inst_valid_next_s  = 1'b0;
      instruction_next_s = NOP;
      pc_out_next_s      = 32'h00000000;
    end else if (remain_s == {CW{1'b0}}) begin
      inst_valid_next_s  = 1'b1;
      instruction_next_s = i_rdata;
      pc_out_next_s      = i_addr_r;
    end else begin
      inst_valid_next_s  = 1'b1;
      instruction_next_s = q_inst_r[rd_ptr_next_s];
      pc_out_next_s      = q_pc_r[rd_ptr_next_s];
    end
  end

  // State, handshake, queue storage and registered head outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_FETCH;
      i_addr_r      <= RESET_PC;
      i_read_r      <= 1'b0;
      redir_pc_r    <= RESET_PC;
      wr_ptr_r      <= {PW{1'b0}};
      rd_ptr_r      <= {PW{1'b0}};
      count_r       <= {CW{1'b0}};
      inst_valid_r  <= 1'b0;
      instruction_r <= NOP;
      pc_out_r      <= 32'h00000000;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_pc_r[i]   <= 32'h00000000;
        q_inst_r[i] <= NOP;
      end
    end else begin
      state_r       <= state_next_s;
      i_addr_r      <= i_addr_next_s;
      i_read_r      <= i_read_next_s;
      redir_pc_r    <= redir_pc_next_s;
      count_r       <= count_next_s;
      inst_valid_r  <= inst_valid_next_s;
      instruction_r <= instruction_next_s;
      pc_out_r      <= pc_out_next_s;
      if (ex_load_pc) begin
        wr_ptr_r <= {PW{1'b0}};
        rd_ptr_r <= {PW{1'b0}};
      end else begin
        rd_ptr_r <= rd_ptr_next_s;
        if (enq_s) begin
          q_pc_r[wr_ptr_r]   <= i_addr_r;
          q_inst_r[wr_ptr_r] <= i_rdata;
          wr_ptr_r           <= wr_ptr_r + 1'b1;
        end else begin
          wr_ptr_r <= wr_ptr_r;
        end
      end
    end
  end

  assign i_addr      = i_addr_r;
  assign i_read      = i_read_r;
  assign inst_valid  = inst_valid_r;
  assign instruction = instruction_r;
  assign pc_out      = pc_out_r;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_r, perf_discarded_r;

  // Saturating counters of enqueued words and redirect-dropped responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_r   <= 32'h00000000;
      perf_discarded_r <= 32'h00000000;
    end else begin
      if (enq_s && (perf_fetched_r != 32'hFFFFFFFF)) begin
        perf_fetched_r <= perf_fetched_r + 32'd1;
      end else begin
        perf_fetched_r <= perf_fetched_r;
      end
      if (drop_s && (perf_discarded_r != 32'hFFFFFFFF)) begin
        perf_discarded_r <= perf_discarded_r + 32'd1;
      end else begin
        perf_discarded_r <= perf_discarded_r;
      end
    end
  end

  assign perf_fetched   = perf_fetched_r;
  assign perf_discarded = perf_discarded_r;
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of pipeline control/decode.
- Owns the fetch PC and drives the instruction-memory read handshake.
- Buffers returned words in a small instruction queue and presents a {pc, instruction, valid} head to decode.
- On an EX-stage redirect, flushes the queue and safely discards any in-flight response.

Parameters:
- RESET_PC, 32'h00000060, first fetch address after reset.
- QUEUE_DEPTH, 2, instruction queue entries (power of two, ≥2).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous, active-low reset
- i_addr  output  32  instruction memory address, word aligned
- i_read  output  1  read request; held with stable i_addr until i_resp
- i_rdata  input  32  read data, valid only when i_resp=1
- i_resp  input  1  single-cycle response pulse
- ex_load_pc  input  1  redirect from EX (taken branch/jump)
- ex_target  input  32  redirect target PC
- stall_id  input  1  decode not accepting this cycle
- inst_valid  output  1  queue head valid
- instruction  output  32  queue head word; 32'h00000013 (NOP) when empty
- pc_out  output  32  PC of queue head; 0 when empty

Behaviour:
- Reset (async assert, clk-synchronous release):
  - i_read=0, i_addr=RESET_PC, queue empty, inst_valid=0, instruction=NOP, pc_out=0, FSM=FETCH, counters 0.
  - First request is issued the first cycle after release.
- Dequeue: when inst_valid && !stall_id && !ex_load_pc, the head pops at the clock edge.
- Issue rule: i_read=1 only when (queue count + outstanding) < QUEUE_DEPTH. The outstanding request reserves a slot, so the queue never overflows.
- Handshake:
  - i_read and i_addr are registered and stay constant until i_resp.
  - A request cannot be withdrawn.
  - Back-to-back: i_read may stay high, and i_addr advances by 4 the cycle after each i_resp.
- Latency: i_resp in cycle t → word in queue and visible at head (if queue empty) in cycle t+1.
- FSM states:
  - FETCH: normal operation. i_resp enqueues {fetch_pc, i_rdata}; fetch_pc += 4.
  - HOLD: no request outstanding because the queue is full. Return to FETCH when a slot frees (request issued the cycle after the pop).
  - DRAIN: a request is outstanding but stale. Keep i_read/i_addr unchanged. On i_resp, discard the data, set i_addr=redirect PC, go to FETCH.
- Redirect (ex_load_pc=1 in cycle t), highest priority:
  - Queue cleared at edge t+1 (inst_valid=0 in t+1). No dequeue in t.
  - fetch_pc ← {ex_target[31:2], 2'b00}.
  - Request outstanding and no i_resp in t → DRAIN.
  - i_resp in t → data discarded; new request at target issued in t+1.
  - No request outstanding → FETCH; request at target issued in t+1.
  - Redirect while in DRAIN: update the saved target, stay in DRAIN.
- Simultaneous enqueue and dequeue: allowed; count unchanged, FIFO order preserved.
- Pointer wrap: read and write pointers are modulo QUEUE_DEPTH. Full and empty are derived from a separate count register.
- Reset mid-request: the outstanding request is abandoned. The memory side is reset by the same rst_n.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined:
  - Adds outputs perf_fetched[31:0] (count of enqueued words) and perf_discarded[31:0] (responses dropped by a redirect, either in DRAIN or same-cycle).
  - Both counters saturate at 32'hFFFFFFFF and reset to 0.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, memory responds 1 cycle after each request, stall_id=0:
  - i_addr sequence 0x60, 0x64, 0x68.
  - pc_out follows 1 cycle after each i_resp.
  - inst_valid is continuous after the first word.
- stall_id held high, 3 responses available:
  - After 2 enqueues, i_read=0 (HOLD); head stays pc 0x60.
  - Release stall → i_read reasserts the cycle after the first pop, at 0x68.
- ex_load_pc=1, ex_target=0x200, while the request to 0x70 is pending (resp 3 cycles later):
  - i_addr stays 0x70 until i_resp; that word is dropped (perf_discarded=1).
  - Next cycle i_addr=0x200; the first valid head is pc 0x200.
- ex_load_pc coincides with i_resp:
  - The word is dropped and the queue is emptied.
  - i_addr=0x200 the next cycle; no stale word ever appears with inst_valid=1.
- ex_target=0x203 → fetch at 0x200. A second redirect to 0x400 during DRAIN → first fetch after drain is 0x400.
- rst_n asserted mid-request (asynchronously, between edges) → i_read=0, inst_valid=0, instruction=0x00000013 immediately; restart at 0x60.
